foo_delta_stream: RTL and testbench

Downstream consumer of the `foo_impl` accumulator: samples the 32-bit accumulator output `x` on request and computes the per-sample increment (current minus previous). It buffers increments in a small first-word-fall-through FIFO and streams them out over a valid/ready handshake. It flags and counts samples lost to back-pressure.

---
 rtl/foo_pkg.sv | 9 +
 rtl/foo_delta_fifo.sv | 65 ++++++
 rtl/foo_delta_stream.sv | 91 +++++++++
 tb/tb_foo_delta_stream.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/foo_pkg.sv
// Shared types and defaults for the foo accumulator delta-stream slice.
package foo_pkg;

   typedef enum logic {PRIME, RUN} foo_delta_state_e;

   localparam int FOO_DATA_W      = 32;
   localparam int FOO_DELTA_DEPTH = 8;

endpackage

// File: rtl/foo_delta_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a single subtraction.
module foo_delta_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [AW:0] PTR_FULL = DEPTH[AW:0];

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign count = wptr_q - rptr_q;
   assign empty = (count == '0);
   assign full  = (count == PTR_FULL);
   // Head reads as zero when empty so the output goes quiet as soon as reset clears the pointers.
   assign head  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      mem_d  = mem_q;
      if (do_push) begin
         wptr_d                    = wptr_q + PTR_ONE;
         mem_d[wptr_q[AW-1:0]]     = push_data;
      end
      if (do_pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/foo_delta_stream.sv
// Samples the foo_impl accumulator, streams per-sample increments through a
// FWFT FIFO, and tracks increments lost to back-pressure.
module foo_delta_stream
   import foo_pkg::*;
#(
   parameter int WIDTH = FOO_DATA_W,
   parameter int DEPTH = FOO_DELTA_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         x,
   input  logic                     sample_en,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_count
);

   foo_delta_state_e state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_count_q, drop_count_d;

   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             want_push;
   logic             push;
   logic             drop;
   logic [WIDTH-1:0] delta;

   assign delta     = x - prev_q;
   assign pop       = !fifo_empty && out_ready;
   assign want_push = (state_q == RUN) && sample_en;
   // A full FIFO still takes the push when the head leaves in the same cycle.
   assign push      = want_push && (!fifo_full || pop);
   assign drop      = want_push && fifo_full && !pop;

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (sample_en) begin
         state_d = RUN;
         prev_d  = x;
      end
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= PRIME;
         prev_q       <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   foo_delta_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (delta),
      .pop       (pop),
      .head      (out_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (count)
   );

   assign out_valid  = !fifo_empty;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_foo_delta_stream.sv
// Directed bench for foo_delta_stream: table of single-cycle vectors plus
// hand-written multi-cycle sequences with hand-computed expectations.
module tb_foo_delta_stream;

   logic        clk;
   logic        rst;
   logic [31:0] x;
   logic        sample_en;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  count;
   logic        overflow;
   logic [15:0] drop_count;

   int unsigned checks;
   int unsigned errors;

   foo_delta_stream #(
      .WIDTH (32),
      .DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .x          (x),
      .sample_en  (sample_en),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        se;
      logic [31:0] xv;
      logic        rdy;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [3:0]  exp_count;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sample_en = 1'b0;
      out_ready = 1'b0;
      x = '0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   logic [31:0] xacc;
   logic [31:0] drain_exp [8];

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      sample_en = 1'b0;
      out_ready = 1'b0;
      x = '0;

      // {sample_en, x, out_ready, exp out_valid, exp out_data, exp count} after the edge
      vecs[0] = '{1'b1, 32'd10,         1'b1, 1'b0, 32'd0,          4'd0};
      vecs[1] = '{1'b1, 32'd15,         1'b1, 1'b1, 32'd5,          4'd1};
      vecs[2] = '{1'b1, 32'd20,         1'b1, 1'b1, 32'd5,          4'd1};
      vecs[3] = '{1'b1, 32'd25,         1'b1, 1'b1, 32'd5,          4'd1};
      vecs[4] = '{1'b0, 32'd25,         1'b1, 1'b0, 32'd0,          4'd0};
      vecs[5] = '{1'b1, 32'hFFFF_FFFE,  1'b1, 1'b1, 32'hFFFF_FFE5,  4'd1};
      vecs[6] = '{1'b1, 32'h0000_0003,  1'b1, 1'b1, 32'd5,          4'd1};
      vecs[7] = '{1'b0, 32'h0000_0003,  1'b1, 1'b0, 32'd0,          4'd0};

      #2;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_count", {28'd0, count}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_drop", {16'd0, drop_count}, 32'd0);
      do_reset();

      for (int i = 0; i < 8; i++) begin
         sample_en = vecs[i].se;
         x         = vecs[i].xv;
         out_ready = vecs[i].rdy;
         step();
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
         chk($sformatf("vec%0d_count", i), {28'd0, count}, {28'd0, vecs[i].exp_count});
      end

      // Fill past full: deltas 1..10 with no consumer, 9 and 10 dropped.
      do_reset();
      xacc = 32'd1000;
      sample_en = 1'b1; x = xacc; out_ready = 1'b0;
      step();
      for (int i = 1; i <= 10; i++) begin
         xacc = xacc + i;
         x = xacc;
         step();
      end
      chk("full_count", {28'd0, count}, 32'd8);
      chk("full_overflow", {31'd0, overflow}, 32'd1);
      chk("full_drop", {16'd0, drop_count}, 32'd2);
      chk("full_head", out_data, 32'd1);

      xacc = xacc + 100;
      x = xacc; out_ready = 1'b1;
      step();
      chk("pushpop_count", {28'd0, count}, 32'd8);
      chk("pushpop_drop", {16'd0, drop_count}, 32'd2);
      chk("pushpop_head", out_data, 32'd2);

      drain_exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd100};
      sample_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("drain%0d_data", k), out_data, drain_exp[k]);
         chk($sformatf("drain%0d_count", k), {28'd0, count}, 32'(8 - k));
         step();
      end
      chk("drained_valid", {31'd0, out_valid}, 32'd0);
      chk("drained_count", {28'd0, count}, 32'd0);
      chk("drained_overflow", {31'd0, overflow}, 32'd1);

      // Queue three entries, then reset between edges.
      out_ready = 1'b0; sample_en = 1'b1;
      for (int i = 11; i <= 13; i++) begin
         xacc = xacc + i;
         x = xacc;
         step();
      end
      sample_en = 1'b0;
      chk("queued_count", {28'd0, count}, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("async_valid", {31'd0, out_valid}, 32'd0);
      chk("async_data", out_data, 32'd0);
      chk("async_count", {28'd0, count}, 32'd0);
      chk("async_overflow", {31'd0, overflow}, 32'd0);
      chk("async_drop", {16'd0, drop_count}, 32'd0);
      #2;
      rst = 1'b0;
      step();
      sample_en = 1'b1; x = 32'd50; out_ready = 1'b1;
      step();
      chk("reprime_valid", {31'd0, out_valid}, 32'd0);
      chk("reprime_count", {28'd0, count}, 32'd0);
      x = 32'd60;
      step();
      chk("rerun_valid", {31'd0, out_valid}, 32'd1);
      chk("rerun_data", out_data, 32'd10);

      // Stall with a head entry present while more samples arrive behind it.
      do_reset();
      sample_en = 1'b1; x = 32'd0; out_ready = 1'b0;
      step();
      x = 32'd7;
      step();
      for (int c = 0; c < 5; c++) begin
         x = x + 32'd1;
         step();
         chk($sformatf("hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
         chk($sformatf("hold%0d_data", c), out_data, 32'd7);
         chk($sformatf("hold%0d_count", c), {28'd0, count}, 32'(c + 2));
      end
      sample_en = 1'b0; out_ready = 1'b1;
      step();
      chk("hold_release_data", out_data, 32'd1);
      chk("hold_release_count", {28'd0, count}, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
